led_bank_arbiter: RTL and testbench

Arbitrates the shared 6-LED status bank between `NUM_REQ` requesters, for example the alarm, link and self-test sources. Each requester holds `req` high and presents a 6-bit pattern. The arbiter grants the bank to one requester at a time using round-robin order and holds the grant for a fixed dwell time. It then releases the bank with a `done` pulse. Outputs drive the `led_enable` and `mtne_mode` inputs of the LED output stage, with an optional maintenance override.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_bank_arbiter_if.sv | 39 +++
 rtl/led_tick_gen.sv | 48 ++++
 rtl/led_bank_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_led_bank_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the status-LED bank logic: the bank width, the
// all-on pattern shown during maintenance, and the arbiter state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package led_pkg;

  localparam int LED_COUNT = 6;

  localparam logic [LED_COUNT-1:0] LED_ALL_ON = 6'h3F;

  // MTNE is only reachable when the maintenance override is compiled in.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    MTNE    = 2'd3
  } led_arb_state_t;

endpackage

// File: rtl/led_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// led_bank_arbiter_if
// Bundles the requester-facing and LED-stage-facing signals of the LED bank
// arbiter.
//   req          requester request levels (one bit per requester)
//   req_pattern  requester i pattern at bits [6i+5:6i]
//   mtne_req     maintenance override request
//   grant        one-hot current owner, zero when idle
//   done         one-cycle pulse on normal completion of the owner's dwell
//   led_enable   latched pattern of the current owner
//   mtne_mode    maintenance override active
//   busy         arbiter is not idle
// Modports: master = requester/system side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface led_bank_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import led_pkg::*;

  logic [NUM_REQ-1:0]           req;
  logic [LED_COUNT*NUM_REQ-1:0] req_pattern;
  logic                         mtne_req;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic [LED_COUNT-1:0]         led_enable;
  logic                         mtne_mode;
  logic                         busy;

  modport master (
    output req, req_pattern, mtne_req,
    input  grant, done, led_enable, mtne_mode, busy
  );

  modport slave (
    input  req, req_pattern, mtne_req,
    output grant, done, led_enable, mtne_mode, busy
  );

endinterface

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Free-running divider that emits a one-cycle tick every TICK_DIV clocks.
// Also used by the LED output stage in place of a derived slow clock.
//   clock  in   system clock, posedge
//   reset  in   synchronous active-low reset
//   clear  in   holds the divider at zero while high (no tick)
//   tick   out  one-cycle pulse on the cycle the divider wraps
// -----------------------------------------------------------------------------
module led_tick_gen #(
  parameter int TICK_DIV = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (count_reg == CNT_LAST) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // The tick marks the last count of a period, so the consumer acts on the
  // same edge at which the divider wraps.
  assign tick = !clear && (count_reg == CNT_LAST);

endmodule

// File: rtl/led_bank_arbiter.sv
// -----------------------------------------------------------------------------
// led_bank_arbiter
// Round-robin owner selection for the shared 6-LED status bank. The winner's
// pattern is latched and held for DWELL_TICKS ticks of TICK_DIV clocks, then
// the bank is released with a done pulse. Dropping req during the dwell
// aborts the grant without done.
// Optional feature macro: LED_ARB_MTNE_EN -- maintenance override; mtne_req
// forces all LEDs on and drops any owner. Without it mtne_req is ignored and
// mtne_mode is tied low.
// Ports:
//   clock  in   system clock, posedge
//   reset  in   synchronous active-low reset
//   bus    led_bank_arbiter_if.slave (req, req_pattern, mtne_req in;
//          grant, done, led_enable, mtne_mode, busy out)
// -----------------------------------------------------------------------------
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_DIV    = 10000000,
  parameter int DWELL_TICKS = 8
) (
  input  logic                clock,
  input  logic                reset,
  led_bank_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW_W  = $clog2(DWELL_TICKS) + 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_TICKS - 1);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NUM_REQ - 1);

  led_arb_state_t       state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [NUM_REQ-1:0]   done_reg, done_next;
  logic [LED_COUNT-1:0] led_reg, led_next;
  logic [IDX_W-1:0]     last_reg, last_next;
  logic [IDX_W-1:0]     owner_reg, owner_next;
  logic [DW_W-1:0]      dwell_reg, dwell_next;

  logic                 tick;
  logic                 tick_clear;

  logic                 rr_found;
  logic [IDX_W-1:0]     rr_winner;
  int                   rr_idx;

  logic [LED_COUNT-1:0] pattern [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pattern
    assign pattern[gi] = bus.req_pattern[gi*LED_COUNT +: LED_COUNT];
  end

  // The divider only runs while a grant is held; it sits at zero otherwise,
  // so every dwell starts from a full tick period.
  assign tick_clear = (state_reg != HOLD);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Round-robin search starting just after the previous owner.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(last_reg) + k) % NUM_REQ;
      if (!rr_found && bus.req[IDX_W'(rr_idx)]) begin
        rr_found  = 1'b1;
        rr_winner = IDX_W'(rr_idx);
      end
    end
  end

`ifdef LED_ARB_MTNE_EN
  logic mtne_reg, mtne_next;
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    done_next  = '0;
    led_next   = led_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    dwell_next = dwell_reg;
`ifdef LED_ARB_MTNE_EN
    mtne_next  = mtne_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          state_next = HOLD;
          owner_next = rr_winner;
          grant_next = NUM_REQ'(1) << rr_winner;
          led_next   = pattern[rr_winner];
          dwell_next = '0;
        end
      end

      HOLD: begin
        // An owner giving up the bank takes precedence over completion.
        if (!bus.req[owner_reg]) begin
          state_next = RELEASE;
          grant_next = '0;
          led_next   = '0;
          last_next  = owner_reg;
        end else if (tick) begin
          if (dwell_reg == DWELL_LAST) begin
            state_next = RELEASE;
            grant_next = '0;
            led_next   = '0;
            last_next  = owner_reg;
            done_next  = grant_reg;
          end else begin
            dwell_next = dwell_reg + DW_W'(1);
          end
        end
      end

      // Outputs were already cleared on entry; this cycle carries done.
      RELEASE: begin
        state_next = IDLE;
      end

`ifdef LED_ARB_MTNE_EN
      MTNE: begin
        if (!bus.mtne_req) begin
          state_next = IDLE;
          led_next   = '0;
          mtne_next  = 1'b0;
        end
      end
`endif

      default: begin
        state_next = IDLE;
        grant_next = '0;
        led_next   = '0;
      end
    endcase

`ifdef LED_ARB_MTNE_EN
    // Maintenance overrides everything, including a completion on this
    // edge; the pointer is left where it was so fairness is preserved.
    if (bus.mtne_req) begin
      state_next = MTNE;
      grant_next = '0;
      done_next  = '0;
      led_next   = LED_ALL_ON;
      last_next  = last_reg;
      dwell_next = '0;
      mtne_next  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      done_reg  <= '0;
      led_reg   <= '0;
      last_reg  <= LAST_INIT;
      owner_reg <= '0;
      dwell_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      led_reg   <= led_next;
      last_reg  <= last_next;
      owner_reg <= owner_next;
      dwell_reg <= dwell_next;
    end
  end

`ifdef LED_ARB_MTNE_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      mtne_reg <= 1'b0;
    end else begin
      mtne_reg <= mtne_next;
    end
  end

  assign bus.mtne_mode = mtne_reg;
`else
  logic unused_mtne_req;
  assign unused_mtne_req = bus.mtne_req;
  assign bus.mtne_mode   = 1'b0;
`endif

  assign bus.grant      = grant_reg;
  assign bus.done       = done_reg;
  assign bus.led_enable = led_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_bank_arbiter
// Self-checking bench for led_bank_arbiter with NUM_REQ=4, TICK_DIV=4,
// DWELL_TICKS=2. Observed vector is {grant, done, led_enable, busy, mtne_mode}.
// Honours LED_ARB_MTNE_EN to select the maintenance scenario.
// -----------------------------------------------------------------------------
module tb_led_bank_arbiter;

  localparam int N  = 4;
  localparam int T  = 4;
  localparam int D  = 2;
  localparam int DT = T * D;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  led_bank_arbiter_if #(.NUM_REQ(N)) bus ();

  led_bank_arbiter #(
    .NUM_REQ     (N),
    .TICK_DIV    (T),
    .DWELL_TICKS (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int model_last   = N - 1;

  logic [15:0] obs;
  logic [15:0] expv;

  function automatic logic [15:0] pack_exp(input logic [3:0] g, input logic [3:0] d,
                                           input logic [5:0] led, input logic b, input logic m);
    return {g, d, led, b, m};
  endfunction

  // Winner is the first requester found walking forward from last+1.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[2'((last + k) % N)]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [5:0] pat_of(input logic [6*N-1:0] p, input int i);
    return p[6*i +: 6];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    obs = {bus.grant, bus.done, bus.led_enable, bus.busy, bus.mtne_mode};
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_pattern = '0; bus.mtne_req = 1'b0;
    reset = 1'b0;
    step(); step();
    tests_run++; expv = '0;
    if (obs !== expv) begin tests_failed++; $display("FAIL reset_state: got %h expected %h", obs, expv); end
    reset = 1'b1;
    step();
    tests_run++; expv = '0;
    if (obs !== expv) begin tests_failed++; $display("FAIL reset_idle: got %h expected %h", obs, expv); end
    model_last = N - 1;
  endtask

  task automatic test_round_robin();
    logic [6*N-1:0] p;
    logic [3:0] oh;
    int w;
    p = 24'($urandom);
    bus.req = 4'b1111; bus.req_pattern = p;
    for (int n = 0; n < 5; n++) begin
      w = rr_pick(4'b1111, model_last);
      oh = 4'b1 << w;
      step();
      tests_run++; expv = pack_exp(oh, 4'b0, pat_of(p, w), 1'b1, 1'b0);
      if (obs !== expv) begin tests_failed++; $display("FAIL rr_grant%0d: got %h expected %h (owner %0d)", n, obs, expv, w); end
      for (int c = 1; c < DT; c++) step();
      tests_run++;
      if (obs !== expv) begin tests_failed++; $display("FAIL rr_hold%0d: got %h expected %h", n, obs, expv); end
      step();
      tests_run++; expv = pack_exp(4'b0, oh, 6'h00, 1'b1, 1'b0);
      if (obs !== expv) begin tests_failed++; $display("FAIL rr_done%0d: got %h expected %h", n, obs, expv); end
      model_last = w;
      step();
      tests_run++; expv = '0;
      if (obs !== expv) begin tests_failed++; $display("FAIL rr_gap%0d: got %h expected %h", n, obs, expv); end
    end
    bus.req = '0;
  endtask

  task automatic test_abort();
    logic [6*N-1:0] p;
    int w;
    p = 24'($urandom);
    bus.req = 4'b0111; bus.req_pattern = p;
    w = rr_pick(4'b0111, model_last);
    step();
    tests_run++; expv = pack_exp(4'b1 << w, 4'b0, pat_of(p, w), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL abort_grant: got %h expected %h", obs, expv); end
    step(); step();
    bus.req = 4'b0101;
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b0, 6'h00, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL abort_release: got %h expected %h", obs, expv); end
    model_last = w;
    step();
    tests_run++; expv = '0;
    if (obs !== expv) begin tests_failed++; $display("FAIL abort_idle: got %h expected %h", obs, expv); end
    w = rr_pick(4'b0101, model_last);
    step();
    tests_run++; expv = pack_exp(4'b1 << w, 4'b0, pat_of(p, w), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL abort_next_grant: got %h expected %h", obs, expv); end
    for (int c = 1; c < DT; c++) step();
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b1 << w, 6'h00, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL abort_next_done: got %h expected %h", obs, expv); end
    model_last = w;
    bus.req = '0;
    step();
  endtask

  task automatic test_single();
    logic [6*N-1:0] p;
    p = 24'($urandom);
    p[17:12] = 6'h15;
    bus.req = 4'b0100; bus.req_pattern = p;
    step();
    tests_run++; expv = pack_exp(4'b0100, 4'b0, 6'h15, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL single_grant: got %h expected %h", obs, expv); end
    for (int c = 1; c < DT; c++) begin
      step();
      tests_run++;
      if (obs !== expv) begin tests_failed++; $display("FAIL single_hold c%0d: got %h expected %h", c, obs, expv); end
    end
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b0100, 6'h00, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL single_done: got %h expected %h", obs, expv); end
    model_last = 2;
    bus.req = '0;
    step();
    tests_run++; expv = '0;
    if (obs !== expv) begin tests_failed++; $display("FAIL single_idle: got %h expected %h", obs, expv); end
  endtask

  task automatic test_pattern_freeze();
    logic [6*N-1:0] p;
    p = 24'($urandom);
    p[23:18] = 6'h01;
    bus.req = 4'b1000; bus.req_pattern = p;
    step();
    tests_run++; expv = pack_exp(4'b1000, 4'b0, 6'h01, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL freeze_grant: got %h expected %h", obs, expv); end
    p[23:18] = 6'h3E;
    bus.req_pattern = p;
    for (int c = 1; c < DT; c++) begin
      step();
      tests_run++;
      if (obs !== expv) begin tests_failed++; $display("FAIL freeze_hold c%0d: got %h expected %h", c, obs, expv); end
    end
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b1000, 6'h00, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL freeze_done: got %h expected %h", obs, expv); end
    model_last = 3;
    bus.req = '0;
    step();
  endtask

  task automatic test_reset_mid_hold();
    logic [6*N-1:0] p;
    int w;
    p = 24'($urandom);
    bus.req = 4'b0010; bus.req_pattern = p;
    step();
    tests_run++; expv = pack_exp(4'b0010, 4'b0, pat_of(p, 1), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL rst_grant: got %h expected %h", obs, expv); end
    step(); step();
    reset = 1'b0; bus.req = 4'b1111;
    step();
    tests_run++; expv = '0;
    if (obs !== expv) begin tests_failed++; $display("FAIL rst_clear: got %h expected %h", obs, expv); end
    reset = 1'b1;
    model_last = N - 1;
    w = rr_pick(4'b1111, model_last);
    step();
    tests_run++; expv = pack_exp(4'b1 << w, 4'b0, pat_of(p, w), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL rst_regrant: got %h expected %h", obs, expv); end
    for (int c = 1; c < DT; c++) step();
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b1 << w, 6'h00, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL rst_done: got %h expected %h", obs, expv); end
    model_last = w;
    bus.req = '0;
    step();
  endtask

`ifdef LED_ARB_MTNE_EN
  task automatic test_mtne();
    logic [6*N-1:0] p;
    int w;
    p = 24'($urandom);
    bus.req = 4'b0100; bus.req_pattern = p;
    step();
    for (int c = 1; c < DT; c++) step();
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b0100, 6'h00, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_pre_done: got %h expected %h", obs, expv); end
    model_last = 2;
    step();
    step();
    tests_run++; expv = pack_exp(4'b0100, 4'b0, pat_of(p, 2), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_grant2: got %h expected %h", obs, expv); end
    step();
    bus.mtne_req = 1'b1; bus.req = 4'b1100;
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b0, 6'h3F, 1'b1, 1'b1);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_enter: got %h expected %h", obs, expv); end
    step();
    tests_run++;
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_stay: got %h expected %h", obs, expv); end
    bus.mtne_req = 1'b0;
    step();
    tests_run++; expv = '0;
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_exit: got %h expected %h", obs, expv); end
    w = rr_pick(4'b1100, model_last);
    step();
    tests_run++; expv = pack_exp(4'b1 << w, 4'b0, pat_of(p, w), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_resume: got %h expected %h", obs, expv); end
    for (int c = 1; c < DT; c++) step();
    bus.mtne_req = 1'b1;
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b0, 6'h3F, 1'b1, 1'b1);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_vs_done: got %h expected %h", obs, expv); end
    bus.mtne_req = 1'b0;
    step();
    w = rr_pick(4'b1100, model_last);
    step();
    tests_run++; expv = pack_exp(4'b1 << w, 4'b0, pat_of(p, w), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_last_kept: got %h expected %h", obs, expv); end
    for (int c = 1; c < DT; c++) step();
    step();
    model_last = w;
    bus.req = '0;
    step();
  endtask
`else
  task automatic test_mtne_ignored();
    logic [6*N-1:0] p;
    int w;
    p = 24'($urandom);
    bus.req = 4'b0100; bus.req_pattern = p;
    w = rr_pick(4'b0100, model_last);
    step();
    bus.mtne_req = 1'b1;
    for (int c = 1; c < DT; c++) step();
    tests_run++; expv = pack_exp(4'b1 << w, 4'b0, pat_of(p, w), 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_ignored_hold: got %h expected %h", obs, expv); end
    step();
    tests_run++; expv = pack_exp(4'b0, 4'b1 << w, 6'h00, 1'b1, 1'b0);
    if (obs !== expv) begin tests_failed++; $display("FAIL mtne_ignored_done: got %h expected %h", obs, expv); end
    model_last = w;
    bus.mtne_req = 1'b0; bus.req = '0;
    step();
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r;
    logic [6*N-1:0] p;
    logic [3:0] oh;
    logic [5:0] held;
    int w;
    int abort_at;
    bit abort_en;
    bit ended;
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      p = 24'($urandom);
      bus.req = r; bus.req_pattern = p;
      w = rr_pick(r, model_last);
      oh = 4'b1 << w;
      held = pat_of(p, w);
      step();
      tests_run++; expv = pack_exp(oh, 4'b0, held, 1'b1, 1'b0);
      if (obs !== expv) begin tests_failed++; $display("FAIL rand%0d_grant: got %h expected %h", t, obs, expv); end
      abort_en = ($urandom_range(0, 1) == 1);
      abort_at = $urandom_range(1, DT - 1);
      ended = 1'b0;
      for (int c = 1; c < DT; c++) begin
        if (!ended) begin
          if (abort_en && c == abort_at) begin
            r = r & ~oh;
            bus.req = r;
            step();
            tests_run++; expv = pack_exp(4'b0, 4'b0, 6'h00, 1'b1, 1'b0);
            if (obs !== expv) begin tests_failed++; $display("FAIL rand%0d_abort: got %h expected %h", t, obs, expv); end
            ended = 1'b1;
          end else begin
            r = 4'($urandom_range(0, 15)) | oh;
            bus.req = r; bus.req_pattern = 24'($urandom);
            step();
            tests_run++; expv = pack_exp(oh, 4'b0, held, 1'b1, 1'b0);
            if (obs !== expv) begin tests_failed++; $display("FAIL rand%0d_hold c%0d: got %h expected %h", t, c, obs, expv); end
          end
        end
      end
      if (!ended) begin
        step();
        tests_run++; expv = pack_exp(4'b0, oh, 6'h00, 1'b1, 1'b0);
        if (obs !== expv) begin tests_failed++; $display("FAIL rand%0d_done: got %h expected %h", t, obs, expv); end
      end
      model_last = w;
      step();
      tests_run++; expv = '0;
      if (obs !== expv) begin tests_failed++; $display("FAIL rand%0d_idle: got %h expected %h", t, obs, expv); end
    end
    bus.req = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_abort();
    test_single();
    test_pattern_freeze();
    test_reset_mid_hold();
`ifdef LED_ARB_MTNE_EN
    test_mtne();
`else
    test_mtne_ignored();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
